// File: rtl/alu_pkg.sv
// alu_pkg: shared constants and types for the multiply result path
// Holds the default bus width, the status-flag bit positions and the capture-state encoding.
package alu_pkg;
    localparam int DEF_DATA_W = 8;
    localparam int FLAG_ZERO  = 0;
    localparam int FLAG_NEG   = 1;
    localparam int FLAG_OVF   = 2;
    typedef enum logic {IDLE = 1'b0, HI_HELD = 1'b1} cap_state_e;
endpackage

// File: rtl/result_fifo.sv
// result_fifo: small synchronous FIFO with a head output and a drop indication
// Ports: clk, rst (async active-low), push/din write side, pop read side,
//        head (zero when empty), full, empty, drop (push lost to a full FIFO this cycle).
module result_fifo #(
    parameter int WIDTH = 19,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty,
    output logic             drop
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic             do_push, do_pop;

    always_comb begin
        empty    = cnt_q == '0;
        full     = cnt_q == (AW+1)'(DEPTH);
        do_pop   = pop && !empty;
        // a same-cycle pop frees the slot the push needs
        do_push  = push && (!full || do_pop);
        drop     = push && !do_push;
        wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = do_pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        cnt_d    = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        mem_d    = mem_q;
        if (do_push) mem_d[wr_ptr_q] = din;
        head     = empty ? '0 : mem_q[rd_ptr_q];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            mem_q    <= mem_d;
        end
    end
endmodule

// File: rtl/mul_result_collector.sv
// mul_result_collector: reassembles the byte-serial product, flags it and queues it for the ALU
// Ports: clk, rst (async active-low), enable, out_bus/hi_strobe/lo_strobe from the controller,
//        res_valid/res_ready/res_product/res_flags to the consumer, full, seq_err (sticky), drop_cnt.
module mul_result_collector
    import alu_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [DATA_W-1:0] out_bus,
    input  logic              hi_strobe,
    input  logic              lo_strobe,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [2*DATA_W-1:0] res_product,
    output logic [2:0]        res_flags,
    output logic              full,
    output logic              seq_err,
    output logic [7:0]        drop_cnt
);
    cap_state_e          state_q, state_d;
    logic [DATA_W-1:0]   hi_q, hi_d;
    logic                seq_err_q, seq_err_d;
    logic [7:0]          drop_cnt_q, drop_cnt_d;
    logic                hi_only, lo_only, both, load_hi, push, seq_set, empty, drop;
    logic [2*DATA_W-1:0] product;
    logic [2:0]          flags;
    logic [2*DATA_W+2:0] head;
    logic [DATA_W:0]     top_bits;

    always_comb begin
        hi_only = enable && hi_strobe && !lo_strobe;
        lo_only = enable && lo_strobe && !hi_strobe;
        both    = enable && hi_strobe && lo_strobe;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (!enable || both)                 state_d = IDLE;
        else if (state_q == IDLE && hi_only) state_d = HI_HELD;
        else if (state_q == HI_HELD && lo_only) state_d = IDLE;
    end

    always_comb begin
        load_hi = hi_only;
        push    = state_q == HI_HELD && lo_only;
        seq_set = both || (state_q == IDLE && lo_only) || (state_q == HI_HELD && hi_only);
    end

    always_comb begin
        product  = {hi_q, out_bus};
        // the product fits in signed DATA_W only when its top DATA_W+1 bits are a sign extension
        top_bits = product[2*DATA_W-1:DATA_W-1];
        flags            = '0;
        flags[FLAG_ZERO] = product == '0;
        flags[FLAG_NEG]  = product[2*DATA_W-1];
        flags[FLAG_OVF]  = !(&top_bits || ~|top_bits);
        hi_d       = load_hi ? out_bus : hi_q;
        seq_err_d  = seq_err_q || seq_set;
        drop_cnt_d = (drop && drop_cnt_q != 8'hFF) ? drop_cnt_q + 8'd1 : drop_cnt_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hi_q       <= '0;
            seq_err_q  <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            hi_q       <= hi_d;
            seq_err_q  <= seq_err_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    result_fifo #(.WIDTH(2*DATA_W+3), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (res_ready),
        .din   ({flags, product}),
        .head  (head),
        .full  (full),
        .empty (empty),
        .drop  (drop)
    );

    always_comb begin
        res_valid   = !empty;
        res_product = head[2*DATA_W-1:0];
        res_flags   = head[2*DATA_W+2:2*DATA_W];
        seq_err     = seq_err_q;
        drop_cnt    = drop_cnt_q;
    end
endmodule
